// File: rtl/mine_placer.sv
// Random mine placement engine: clears a square board, then writes distinct LFSR-chosen mine cells.
// Optional first-click exclusion zone enabled by defining MINE_PLACER_SAFE_START_EN.
module mine_placer #(
  parameter int unsigned BOARD_MAX  = 16,
  parameter int unsigned LFSR_WIDTH = 16,
  parameter int unsigned CNT_W      = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         seed_load_i,
  input  logic [LFSR_WIDTH-1:0]        seed_i,
  input  logic                         start_i,
  input  logic [$clog2(BOARD_MAX):0]   board_size_i,
  input  logic [CNT_W-1:0]             mine_count_i,
  input  logic [$clog2(BOARD_MAX)-1:0] safe_x_i,
  input  logic [$clog2(BOARD_MAX)-1:0] safe_y_i,
  output logic [$clog2(BOARD_MAX)-1:0] mine_rd_x_o,
  output logic [$clog2(BOARD_MAX)-1:0] mine_rd_y_o,
  input  logic                         mine_rd_data_i,
  output logic                         mine_wr_en_o,
  output logic [$clog2(BOARD_MAX)-1:0] mine_wr_x_o,
  output logic [$clog2(BOARD_MAX)-1:0] mine_wr_y_o,
  output logic                         mine_wr_data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [CNT_W-1:0]             placed_cnt_o
);

  localparam int unsigned XW = $clog2(BOARD_MAX);
  localparam int unsigned SW = XW + 1;
  localparam int unsigned WW = ((CNT_W > 2 * SW) ? CNT_W : 2 * SW) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_GEN   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_EVAL  = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [SW-1:0] BMAX = SW'(BOARD_MAX);

  function automatic logic [63:0] tp(input int unsigned n);
    return 64'(1) << (n - 1);
  endfunction

  // Maximal-length tap sets, one bit per tap position (tap n -> bit n-1)
  function automatic logic [63:0] tap_mask(input int unsigned w);
    logic [63:0] m;
    m = '0;
    case (w)
      3:  m = tp(3)  | tp(2);
      4:  m = tp(4)  | tp(3);
      5:  m = tp(5)  | tp(3);
      6:  m = tp(6)  | tp(5);
      7:  m = tp(7)  | tp(6);
      8:  m = tp(8)  | tp(6)  | tp(5)  | tp(4);
      9:  m = tp(9)  | tp(5);
      10: m = tp(10) | tp(7);
      11: m = tp(11) | tp(9);
      12: m = tp(12) | tp(6)  | tp(4)  | tp(1);
      13: m = tp(13) | tp(4)  | tp(3)  | tp(1);
      14: m = tp(14) | tp(5)  | tp(3)  | tp(1);
      15: m = tp(15) | tp(14);
      16: m = tp(16) | tp(15) | tp(13) | tp(4);
      17: m = tp(17) | tp(14);
      18: m = tp(18) | tp(11);
      19: m = tp(19) | tp(6)  | tp(2)  | tp(1);
      20: m = tp(20) | tp(17);
      21: m = tp(21) | tp(19);
      22: m = tp(22) | tp(21);
      23: m = tp(23) | tp(18);
      24: m = tp(24) | tp(23) | tp(22) | tp(17);
      25: m = tp(25) | tp(22);
      26: m = tp(26) | tp(6)  | tp(2)  | tp(1);
      27: m = tp(27) | tp(5)  | tp(2)  | tp(1);
      28: m = tp(28) | tp(25);
      29: m = tp(29) | tp(27);
      30: m = tp(30) | tp(6)  | tp(4)  | tp(1);
      31: m = tp(31) | tp(28);
      32: m = tp(32) | tp(22) | tp(2)  | tp(1);
      33: m = tp(33) | tp(20);
      34: m = tp(34) | tp(27) | tp(2)  | tp(1);
      35: m = tp(35) | tp(33);
      36: m = tp(36) | tp(25);
      37: m = tp(37) | tp(5)  | tp(4)  | tp(3) | tp(2) | tp(1);
      38: m = tp(38) | tp(6)  | tp(5)  | tp(1);
      39: m = tp(39) | tp(35);
      40: m = tp(40) | tp(38) | tp(21) | tp(19);
      41: m = tp(41) | tp(38);
      42: m = tp(42) | tp(41) | tp(20) | tp(19);
      43: m = tp(43) | tp(42) | tp(38) | tp(37);
      44: m = tp(44) | tp(43) | tp(18) | tp(17);
      45: m = tp(45) | tp(44) | tp(42) | tp(41);
      46: m = tp(46) | tp(45) | tp(26) | tp(25);
      47: m = tp(47) | tp(42);
      48: m = tp(48) | tp(47) | tp(21) | tp(20);
      49: m = tp(49) | tp(40);
      50: m = tp(50) | tp(49) | tp(24) | tp(23);
      51: m = tp(51) | tp(50) | tp(36) | tp(35);
      52: m = tp(52) | tp(49);
      53: m = tp(53) | tp(52) | tp(38) | tp(37);
      54: m = tp(54) | tp(53) | tp(18) | tp(17);
      55: m = tp(55) | tp(31);
      56: m = tp(56) | tp(55) | tp(35) | tp(34);
      57: m = tp(57) | tp(50);
      58: m = tp(58) | tp(39);
      59: m = tp(59) | tp(58) | tp(38) | tp(37);
      60: m = tp(60) | tp(59);
      61: m = tp(61) | tp(60) | tp(46) | tp(45);
      62: m = tp(62) | tp(61) | tp(6)  | tp(5);
      63: m = tp(63) | tp(62);
      64: m = tp(64) | tp(63) | tp(61) | tp(60);
      default: m = tp(w);
    endcase
    return m;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] TAPS = LFSR_WIDTH'(tap_mask(LFSR_WIDTH));

  logic [2:0]            state_q, state_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d, lfsr_nxt_c;
  logic [SW-1:0]         bs_q, bs_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [XW-1:0]         sx_q, sx_d, sy_q, sy_d;
  logic [CNT_W-1:0]      placed_q, placed_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  wr_en_q, wr_en_d, wr_data_q, wr_data_d;
  logic [XW-1:0]         wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic [XW-1:0]         rd_x_q, rd_x_d, rd_y_q, rd_y_d;

  logic [SW-1:0]         bs_eff_c;
  logic [WW-1:0]         area_c, lim_c;
  logic [CNT_W-1:0]      cnt_clamp_c;
  logic                  in_range_c, near_c, x_last_c, y_last_c;

  // Right-shift Galois step
  assign lfsr_nxt_c = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

  // Board side and mine count clamping, computed wide enough to never wrap
  always_comb begin
    bs_eff_c = ((board_size_i == '0) || (board_size_i > BMAX)) ? BMAX : board_size_i;
    area_c   = WW'(bs_eff_c) * WW'(bs_eff_c);
`ifdef MINE_PLACER_SAFE_START_EN
    lim_c    = (area_c > WW'(9)) ? area_c - WW'(9) : '0;
`else
    lim_c    = area_c - WW'(1);
`endif
    cnt_clamp_c = (WW'(mine_count_i) > lim_c) ? CNT_W'(lim_c) : mine_count_i;
  end

  assign in_range_c = ({1'b0, rd_x_q} < bs_q) && ({1'b0, rd_y_q} < bs_q);
  assign x_last_c   = ({1'b0, wr_x_q} == bs_q - SW'(1));
  assign y_last_c   = ({1'b0, wr_y_q} == bs_q - SW'(1));

`ifdef MINE_PLACER_SAFE_START_EN
  logic [XW-1:0] dx_c, dy_c;
  assign dx_c   = (rd_x_q >= sx_q) ? rd_x_q - sx_q : sx_q - rd_x_q;
  assign dy_c   = (rd_y_q >= sy_q) ? rd_y_q - sy_q : sy_q - rd_y_q;
  assign near_c = (dx_c <= XW'(1)) && (dy_c <= XW'(1));
`else
  logic unused_safe;
  assign unused_safe = ^{sx_q, sy_q};
  assign near_c      = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    bs_d      = bs_q;
    cnt_d     = cnt_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    placed_d  = placed_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    wr_x_d    = wr_x_q;
    wr_y_d    = wr_y_q;
    rd_x_d    = rd_x_q;
    rd_y_d    = rd_y_q;
    case (state_q)
      S_IDLE: begin
        if (seed_load_i) lfsr_d = (seed_i == '0) ? LFSR_WIDTH'(1) : seed_i;
        if (start_i) begin
          bs_d      = bs_eff_c;
          cnt_d     = cnt_clamp_c;
          sx_d      = safe_x_i;
          sy_d      = safe_y_i;
          placed_d  = '0;
          busy_d    = 1'b1;
          wr_en_d   = 1'b1;
          wr_data_d = 1'b0;
          wr_x_d    = '0;
          wr_y_d    = '0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (x_last_c) begin
          wr_x_d = '0;
          if (y_last_c) begin
            done_d  = (cnt_q == '0);
            state_d = (cnt_q == '0) ? S_DONE : S_GEN;
          end else begin
            wr_y_d  = wr_y_q + XW'(1);
            wr_en_d = 1'b1;
          end
        end else begin
          wr_x_d  = wr_x_q + XW'(1);
          wr_en_d = 1'b1;
        end
      end
      // Read address is registered here so it is on the port throughout CHECK
      S_GEN: begin
        lfsr_d  = lfsr_nxt_c;
        rd_x_d  = lfsr_nxt_c[XW-1:0];
        rd_y_d  = lfsr_nxt_c[2*XW-1:XW];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = (!in_range_c || near_c) ? S_GEN : S_EVAL;
      end
      S_EVAL: begin
        if (mine_rd_data_i) begin
          state_d = S_GEN;
        end else begin
          wr_en_d   = 1'b1;
          wr_data_d = 1'b1;
          wr_x_d    = rd_x_q;
          wr_y_d    = rd_y_q;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        placed_d = placed_q + CNT_W'(1);
        if (placed_d == cnt_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_GEN;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_WIDTH'(1);
      bs_q      <= '0;
      cnt_q     <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      placed_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 1'b0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      bs_q      <= bs_d;
      cnt_q     <= cnt_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      placed_q  <= placed_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
      rd_x_q    <= rd_x_d;
      rd_y_q    <= rd_y_d;
    end
  end

  assign mine_rd_x_o    = rd_x_q;
  assign mine_rd_y_o    = rd_y_q;
  assign mine_wr_en_o   = wr_en_q;
  assign mine_wr_x_o    = wr_x_q;
  assign mine_wr_y_o    = wr_y_q;
  assign mine_wr_data_o = wr_data_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign placed_cnt_o   = placed_q;

endmodule

// File: doc/mine_placer.md
MINE_PLACER -- requirements
Module: mine_placer

Interface
REQ-001 Parameter BOARD_MAX, default 16: maximum board side in cells; power of two, 4..32.
REQ-002 Parameter LFSR_WIDTH, default 16: random state width; SHALL be >= 2*log2(BOARD_MAX) and within 3..64.
REQ-003 Parameter CNT_W, default 10: width of mine_count and placed_cnt.
REQ-004 Port clk  in  1: rising-edge clock for all state.
REQ-005 Port rst_n  in  1: asynchronous active-low reset.
REQ-006 Ports seed_load in 1 and seed in LFSR_WIDTH: load the random state from seed while in IDLE.
REQ-007 Ports start in 1, board_size in log2(BOARD_MAX)+1 and mine_count in CNT_W: one-cycle start request; board side; requested mines.
REQ-008 Ports safe_x and safe_y, each in log2(BOARD_MAX): first-click cell (used only under REQ-027).
REQ-009 Ports mine_rd_x and mine_rd_y out, mine_rd_data in 1: board read port; data is valid one cycle after the address is presented.
REQ-010 Ports mine_wr_en out 1, mine_wr_x and mine_wr_y out, mine_wr_data out 1: board write port.
REQ-011 Ports busy out 1, done out 1 (one-cycle pulse), placed_cnt out CNT_W.

Function
REQ-012 The random state SHALL advance through the XAPP052 LFSR next-state function: shift right by one, XOR the width tap mask when bit0 is 1.
REQ-013 A seed of zero SHALL be loaded as 1, so the LFSR never locks up.
REQ-014 FSM states: IDLE, CLEAR, GEN, CHECK, EVAL, WRITE, DONE.
REQ-015 IDLE: start=1 latches board_size, the clamped count and the safe cell, clears placed_cnt, sets busy, and moves to CLEAR; start while busy SHALL be ignored.
REQ-016 CLEAR: one write of 0 per cycle, raster order x fastest, covering board_size x board_size cells; after the last cell, move to GEN.
REQ-017 GEN: advance the LFSR once; x = state[XW-1:0]; y = state[2*XW-1:XW], where XW = log2(BOARD_MAX); move to CHECK.
REQ-018 CHECK: if x >= board_size or y >= board_size, return to GEN; otherwise drive mine_rd_x/y and move to EVAL.
REQ-019 EVAL: if mine_rd_data = 1 (duplicate), return to GEN; otherwise move to WRITE.
REQ-020 WRITE: mine_wr_en=1, mine_wr_data=1 at (x,y); increment placed_cnt; if placed_cnt reaches the latched count, move to DONE, else to GEN.
REQ-021 DONE: pulse done for one cycle, clear busy, return to IDLE.
REQ-022 Count clamp: the latched count = min(mine_count, board_size^2 - 1), computed with no overflow at CNT_W.
REQ-023 mine_count = 0 SHALL complete CLEAR and then go straight to DONE, with no mine writes.
REQ-024 board_size = 0 or board_size > BOARD_MAX SHALL be clamped to BOARD_MAX.
REQ-025 mine_wr_en SHALL be asserted only in the CLEAR and WRITE states; there is at most one write per cycle.

Reset
REQ-026 While rst_n = 0:
  - FSM in IDLE.
  - LFSR state = 1.
  - busy = 0, done = 0, mine_wr_en = 0.
  - placed_cnt = 0; all address outputs = 0.
  - Reset mid-operation aborts placement immediately; the board memory contents are then undefined.

Configuration
REQ-027 Macro MINE_PLACER_SAFE_START_EN:
  - When defined, CHECK also rejects any cell with |x-safe_x| <= 1 and |y-safe_y| <= 1.
  - When defined, the clamp becomes board_size^2 - 9.
  - When undefined, safe_x/safe_y are ignored and the REQ-022 clamp applies.

Verification
REQ-028 seed=16'hACE1, board 8, count 10, start -> 64 clear writes, then exactly 10 distinct mine writes, all with x,y < 8; done pulses once; placed_cnt = 10.
REQ-029 Same seed run twice -> identical sequence of mine coordinates.
REQ-030 board 4, count 100 -> clamped to 15; 15 distinct mines written; done pulses.
REQ-031 seed=0 -> behaves identically to seed=1; no lockup; done within 10000 cycles.
REQ-032 rst_n low during GEN after 3 mines -> busy=0, placed_cnt=0, FSM in IDLE; a new start completes normally.
REQ-033 With MINE_PLACER_SAFE_START_EN, board 8, safe cell (0,0), count 55 -> no mine in x,y <= 1; placed_cnt = 55.
